wb_cpu_master: RTL and testbench

Wishbone initiator that turns CPU-side load/store requests into single-beat Wishbone transfers toward registered-ack slaves such as the TIA, RIOT and cartridge ROM.
- Strobes each transfer for exactly one cycle, so slaves with write side effects (WSYNC, RESPx, HMOVE, CXCLR) see each write once.
- Writes are posted; reads wait for ack.
- Honours the slave-driven CPU stall (WSYNC) before starting any new transfer.

---
 rtl/wb_cpu_master.sv | 142 ++++++++++++++
 tb/tb_wb_cpu_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_master.sv
// Wishbone single-beat initiator for CPU loads/stores: posted writes, blocking reads, stall-aware issue.
// Optional ack timeout is compiled in with `define WB_CPU_MASTER_TIMEOUT_EN.
module wb_cpu_master #(
    parameter int unsigned WB_DATA_WIDTH = 8,
    parameter int unsigned WB_ADDR_WIDTH = 7,
    parameter int unsigned ACK_TIMEOUT   = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cpu_req_i,
    input  logic                     cpu_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] cpu_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] cpu_dat_i,
    output logic                     cpu_ack_o,
    output logic [WB_DATA_WIDTH-1:0] cpu_dat_o,
    input  logic                     stall_i,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic                     ack_i,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    output logic                     busy_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     stb_d;
    logic                     we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_d;
    logic                     cpu_ack_d;
    logic [WB_DATA_WIDTH-1:0] cpu_dat_d;
    logic                     busy_d;
    logic                     err_d;

`ifdef WB_CPU_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (ACK_TIMEOUT == 0);
`endif

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= '0;
            dat_o     <= '0;
            cpu_ack_o <= 1'b0;
            cpu_dat_o <= '0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
`ifdef WB_CPU_MASTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            stb_o     <= stb_d;
            we_o      <= we_d;
            adr_o     <= adr_d;
            dat_o     <= dat_d;
            cpu_ack_o <= cpu_ack_d;
            cpu_dat_o <= cpu_dat_d;
            busy_o    <= busy_d;
            err_o     <= err_d;
`ifdef WB_CPU_MASTER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        stb_d     = 1'b0;
        we_d      = we_o;
        adr_d     = adr_o;
        dat_d     = dat_o;
        cpu_ack_d = 1'b0;
        cpu_dat_d = cpu_dat_o;
        err_d     = 1'b0;
`ifdef WB_CPU_MASTER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Request level is ignored while the previous ack is still visible
                if (cpu_req_i && !stall_i && !cpu_ack_o) begin
                    adr_d     = cpu_adr_i;
                    we_d      = cpu_we_i;
                    dat_d     = cpu_dat_i;
                    stb_d     = 1'b1;
                    cpu_ack_d = cpu_we_i;
                    state_d   = ST_STROBE;
                end
            end
            ST_STROBE: begin
                // Any ack seen here belongs to an earlier transfer
                state_d = ST_WAIT;
`ifdef WB_CPU_MASTER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                    if (!we_o) begin
                        cpu_ack_d = 1'b1;
                        cpu_dat_d = dat_i;
                    end
                end
`ifdef WB_CPU_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    if (!we_o) begin
                        cpu_ack_d = 1'b1;
                        cpu_dat_d = '1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_wb_cpu_master.sv
// Directed bench for wb_cpu_master with a registered-ack slave model (stall raised on writes to 0x02).
module tb_wb_cpu_master;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cpu_req_i, cpu_we_i;
    logic [6:0] cpu_adr_i;
    logic [7:0] cpu_dat_i;
    logic       cpu_ack_o;
    logic [7:0] cpu_dat_o;
    logic       stall_i;
    logic       stb_o, we_o;
    logic [6:0] adr_o;
    logic [7:0] dat_o;
    logic       ack_i;
    logic [7:0] dat_i;
    logic       busy_o, err_o;

    int checks = 0;
    int errors = 0;

    logic       ack_auto = 1'b0;
    logic       ack_force;
    logic [7:0] force_dat;
    logic [7:0] slave_dat = 8'h00;
    logic       stall_q = 1'b0;
    logic       release_req;
    logic       nack_mode;
    logic [7:0] regs [128];
    int         wr_cnt [128];

    always #5 clk = ~clk;

    wb_cpu_master #(.WB_DATA_WIDTH(8), .WB_ADDR_WIDTH(7), .ACK_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
        .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o), .stall_i(stall_i),
        .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i), .busy_o(busy_o), .err_o(err_o)
    );

    assign ack_i   = ack_auto | ack_force;
    assign dat_i   = ack_force ? force_dat : slave_dat;
    assign stall_i = stall_q;

    // Registered-ack slave: one ack per strobe, WSYNC (0x02) write raises stall
    always @(posedge clk) begin
        ack_auto <= 1'b0;
        if (stb_o && !nack_mode) begin
            ack_auto <= 1'b1;
            if (we_o) begin
                regs[adr_o]   <= dat_o;
                wr_cnt[adr_o] <= wr_cnt[adr_o] + 1;
            end else begin
                slave_dat <= (adr_o == 7'h0C) ? 8'h80 : {1'b0, adr_o};
            end
        end
        if (stb_o && we_o && adr_o == 7'h02 && !nack_mode) stall_q <= 1'b1;
        else if (release_req) stall_q <= 1'b0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++; if ({stb_o, we_o, adr_o, dat_o, cpu_ack_o, cpu_dat_o, busy_o, err_o} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {stb_o, we_o, adr_o, dat_o, cpu_ack_o, cpu_dat_o, busy_o, err_o}); end
    endtask

    task automatic test_write;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 7'h09; cpu_dat_i = 8'h84;
        tick; // N+1
        checks++; if (stb_o !== 1'b1) begin errors++; $display("FAIL wr_stb got %b exp 1", stb_o); end
        checks++; if ({we_o, adr_o, dat_o} !== {1'b1, 7'h09, 8'h84}) begin
            errors++; $display("FAIL wr_bus got we=%b adr=%h dat=%h exp 1 09 84", we_o, adr_o, dat_o); end
        checks++; if (cpu_ack_o !== 1'b1) begin errors++; $display("FAIL wr_posted_ack got %b exp 1", cpu_ack_o); end
        cpu_req_i = 1'b0;
        tick; // N+2
        checks++; if ({stb_o, cpu_ack_o, busy_o} !== 3'b001) begin
            errors++; $display("FAIL wr_n2 got stb/ack/busy=%b exp 001", {stb_o, cpu_ack_o, busy_o}); end
        tick; // N+3
        checks++; if ({busy_o, cpu_ack_o} !== 2'b00) begin
            errors++; $display("FAIL wr_n3 got busy/ack=%b exp 00", {busy_o, cpu_ack_o}); end
        checks++; if (wr_cnt[9] !== 1 || regs[9] !== 8'h84) begin
            errors++; $display("FAIL wr_slave got cnt=%0d reg=%h exp 1 84", wr_cnt[9], regs[9]); end
    endtask

    task automatic test_read;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 7'h0C; cpu_dat_i = 8'h00;
        tick; // N+1
        checks++; if ({stb_o, we_o, adr_o, cpu_ack_o} !== {1'b1, 1'b0, 7'h0C, 1'b0}) begin
            errors++; $display("FAIL rd_n1 got stb=%b we=%b adr=%h ack=%b exp 1 0 0c 0", stb_o, we_o, adr_o, cpu_ack_o); end
        tick; // N+2
        checks++; if ({cpu_ack_o, busy_o} !== 2'b01) begin
            errors++; $display("FAIL rd_n2 got ack/busy=%b exp 01", {cpu_ack_o, busy_o}); end
        tick; // N+3
        checks++; if ({cpu_ack_o, busy_o, cpu_dat_o} !== {1'b1, 1'b0, 8'h80}) begin
            errors++; $display("FAIL rd_n3 got ack=%b busy=%b dat=%h exp 1 0 80", cpu_ack_o, busy_o, cpu_dat_o); end
        cpu_req_i = 1'b0;
        tick;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 7'h0D; cpu_dat_i = 8'h55;
        tick;
        cpu_req_i = 1'b0;
        tick; tick;
        checks++; if (cpu_dat_o !== 8'h80) begin errors++; $display("FAIL rd_hold got %h exp 80", cpu_dat_o); end
        checks++; if (regs[13] !== 8'h55) begin errors++; $display("FAIL rd_wr55 got %h exp 55", regs[13]); end
    endtask

    task automatic test_wsync_stall;
        logic stb_seen;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 7'h02; cpu_dat_i = 8'h00;
        tick; // N+1
        checks++; if (cpu_ack_o !== 1'b1) begin errors++; $display("FAIL ws_ack got %b exp 1", cpu_ack_o); end
        cpu_we_i = 1'b0; cpu_adr_i = 7'h0C;
        tick; // N+2
        stb_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (stb_o || !stall_i) stb_seen = 1'b1;
        end
        checks++; if (stb_seen !== 1'b0) begin errors++; $display("FAIL ws_blocked got strobe-or-no-stall=1 exp 0"); end
        release_req = 1'b1;
        tick; // S
        release_req = 1'b0;
        checks++; if ({stall_i, stb_o} !== 2'b00) begin
            errors++; $display("FAIL ws_s got stall/stb=%b exp 00", {stall_i, stb_o}); end
        tick; // S+1
        checks++; if ({stb_o, adr_o, we_o} !== {1'b1, 7'h0C, 1'b0}) begin
            errors++; $display("FAIL ws_s1 got stb=%b adr=%h we=%b exp 1 0c 0", stb_o, adr_o, we_o); end
        tick; tick; // S+3
        checks++; if ({cpu_ack_o, cpu_dat_o} !== {1'b1, 8'h80}) begin
            errors++; $display("FAIL ws_rd got ack=%b dat=%h exp 1 80", cpu_ack_o, cpu_dat_o); end
        cpu_req_i = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic stray;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 7'h06; cpu_dat_i = 8'h1E;
        tick; // N+1
        checks++; if ({stb_o, cpu_ack_o, adr_o} !== {1'b1, 1'b1, 7'h06}) begin
            errors++; $display("FAIL b2b_first got stb=%b ack=%b adr=%h exp 1 1 06", stb_o, cpu_ack_o, adr_o); end
        cpu_adr_i = 7'h07; cpu_dat_i = 8'h44;
        stray = 1'b0;
        tick; if (stb_o || cpu_ack_o) stray = 1'b1;
        tick; if (stb_o || cpu_ack_o) stray = 1'b1;
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL b2b_gap got stray=1 exp 0"); end
        tick; // N+4
        checks++; if ({stb_o, cpu_ack_o, adr_o, dat_o} !== {1'b1, 1'b1, 7'h07, 8'h44}) begin
            errors++; $display("FAIL b2b_second got stb=%b ack=%b adr=%h dat=%h exp 1 1 07 44", stb_o, cpu_ack_o, adr_o, dat_o); end
        cpu_req_i = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (stb_o || cpu_ack_o) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL b2b_tail got stray=1 exp 0"); end
        checks++; if (wr_cnt[6] !== 1 || wr_cnt[7] !== 1 || regs[6] !== 8'h1E || regs[7] !== 8'h44) begin
            errors++; $display("FAIL b2b_slave got cnt6=%0d cnt7=%0d r6=%h r7=%h exp 1 1 1e 44", wr_cnt[6], wr_cnt[7], regs[6], regs[7]); end
    endtask

    task automatic test_mid_reset;
        nack_mode = 1'b1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 7'h10;
        tick; tick; // N+2, in WAIT
        checks++; if ({busy_o, stb_o} !== 2'b10) begin
            errors++; $display("FAIL mr_wait got busy/stb=%b exp 10", {busy_o, stb_o}); end
        rst_i = 1'b1; cpu_req_i = 1'b0;
        tick;
        rst_i = 1'b0; ack_force = 1'b1; force_dat = 8'hAB;
        checks++; if ({stb_o, we_o, adr_o, dat_o, cpu_ack_o, cpu_dat_o, busy_o, err_o} !== '0) begin
            errors++; $display("FAIL mr_outputs got %h exp 0", {stb_o, we_o, adr_o, dat_o, cpu_ack_o, cpu_dat_o, busy_o, err_o}); end
        tick;
        ack_force = 1'b0;
        checks++; if ({cpu_ack_o, cpu_dat_o, busy_o} !== '0) begin
            errors++; $display("FAIL mr_late_ack got ack=%b dat=%h busy=%b exp 0 00 0", cpu_ack_o, cpu_dat_o, busy_o); end
        tick;
    endtask

    task automatic test_timeout;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 7'h20;
`ifdef WB_CPU_MASTER_TIMEOUT_EN
        tick; tick; tick; tick; tick; // N+5, fourth WAIT cycle
        checks++; if ({busy_o, err_o, cpu_ack_o} !== 3'b100) begin
            errors++; $display("FAIL to_pre got busy/err/ack=%b exp 100", {busy_o, err_o, cpu_ack_o}); end
        tick; // N+6
        checks++; if ({cpu_ack_o, err_o, busy_o, cpu_dat_o} !== {1'b1, 1'b1, 1'b0, 8'hFF}) begin
            errors++; $display("FAIL to_abort got ack=%b err=%b busy=%b dat=%h exp 1 1 0 ff", cpu_ack_o, err_o, busy_o, cpu_dat_o); end
        cpu_req_i = 1'b0;
        tick;
        checks++; if ({err_o, cpu_ack_o} !== 2'b00) begin
            errors++; $display("FAIL to_pulse got err/ack=%b exp 00", {err_o, cpu_ack_o}); end
`else
        tick;
        cpu_req_i = 1'b0;
        for (int i = 0; i < 100; i++) tick;
        checks++; if ({busy_o, err_o, cpu_ack_o} !== 3'b100) begin
            errors++; $display("FAIL hang got busy/err/ack=%b exp 100", {busy_o, err_o, cpu_ack_o}); end
`endif
    endtask

    initial begin
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_adr_i = '0; cpu_dat_i = '0;
        ack_force = 1'b0; force_dat = '0; release_req = 1'b0; nack_mode = 1'b0;
        tick; tick;
        test_reset;
        rst_i = 1'b0;
        tick;
        test_write;
        test_read;
        test_wsync_stall;
        test_back_to_back;
        test_mid_reset;
        test_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
